// File: rtl/adc_scan_ctrl.sv
// Round-robin scan sequencer for an 8-channel 12-bit serial ADC with a per-channel
// result bank and a slow-rate, channel-tagged publish to the 7-segment display path.
module adc_scan_ctrl #(
    parameter int unsigned DIV    = 4,
    parameter int unsigned DISP_N = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  ch_mask,
    input  logic [2:0]  disp_ch_sel,
    output logic        adc_sclk,
    output logic        adc_cs_n,
    output logic        adc_din,
    input  logic        adc_dout,
    output logic        busy,
    output logic        sample_valid,
    output logic [2:0]  sample_ch,
    output logic [11:0] sample_data,
    output logic [15:0] disp_data,
    output logic        disp_strobe
);

    localparam int unsigned CNT_W = $clog2(3 * DIV);
    localparam logic [CNT_W-1:0] C_DIV_END = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] C_GAP_END = CNT_W'(3 * DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bit;
    logic             r_sclk;
    logic             r_cs_n;
    logic             r_din;
    logic             r_busy;
    logic [15:0]      r_ctrl;
    logic [11:0]      r_shreg;
    logic [2:0]       r_addr_ch;
    logic [2:0]       r_prev_ch;
    logic             r_primed;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_bit_nxt;
    logic             w_sclk_nxt;
    logic             w_cs_n_nxt;
    logic             w_din_nxt;
    logic             w_busy_nxt;
    logic [15:0]      w_ctrl_nxt;
    logic [11:0]      w_shreg_nxt;
    logic [2:0]       w_addr_ch_nxt;
    logic [2:0]       w_prev_ch_nxt;
    logic             w_primed_nxt;
    logic             w_capture;

    logic             w_go;
    logic [2:0]       w_first_ch;
    logic [2:0]       w_next_ch;
    logic [2:0]       w_idx;
    logic [15:0]      w_word;

    logic [11:0]       r_bank [8];
    logic              r_sample_valid;
    logic [2:0]        r_sample_ch;
    logic [11:0]       r_sample_data;
    logic [DISP_N-1:0] r_disp_cnt;
    logic [15:0]       r_disp_data;
    logic              r_disp_strobe;

    // Channel scheduling: lowest set bit for a fresh scan, next set bit above current otherwise.
    always_comb begin
        w_go       = en && (ch_mask != 8'd0);
        w_first_ch = 3'd0;
        w_next_ch  = r_addr_ch;
        w_idx      = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (ch_mask[i]) begin
                w_first_ch = 3'(i);
            end
        end
        for (int i = 7; i >= 1; i--) begin
            w_idx = r_addr_ch + 3'(i);
            if (ch_mask[w_idx]) begin
                w_next_ch = w_idx;
            end
        end
        w_word = {2'b00, r_addr_ch, 11'd0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit     <= 4'd0;
            r_sclk    <= 1'b1;
            r_cs_n    <= 1'b1;
            r_din     <= 1'b0;
            r_busy    <= 1'b0;
            r_ctrl    <= 16'd0;
            r_shreg   <= 12'd0;
            r_addr_ch <= 3'd0;
            r_prev_ch <= 3'd0;
            r_primed  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit     <= w_bit_nxt;
            r_sclk    <= w_sclk_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_din     <= w_din_nxt;
            r_busy    <= w_busy_nxt;
            r_ctrl    <= w_ctrl_nxt;
            r_shreg   <= w_shreg_nxt;
            r_addr_ch <= w_addr_ch_nxt;
            r_prev_ch <= w_prev_ch_nxt;
            r_primed  <= w_primed_nxt;
        end
    end

    // Frame sequencing; every serial-side output is the registered copy of these next values.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + CNT_W'(1);
        w_bit_nxt     = r_bit;
        w_sclk_nxt    = r_sclk;
        w_cs_n_nxt    = r_cs_n;
        w_din_nxt     = r_din;
        w_busy_nxt    = r_busy;
        w_ctrl_nxt    = r_ctrl;
        w_shreg_nxt   = r_shreg;
        w_addr_ch_nxt = r_addr_ch;
        w_prev_ch_nxt = r_prev_ch;
        w_primed_nxt  = r_primed;
        w_capture     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt  = '0;
                w_sclk_nxt = 1'b1;
                w_cs_n_nxt = 1'b1;
                w_busy_nxt = 1'b0;
                if (w_go) begin
                    w_state_nxt   = S_SETUP;
                    w_cs_n_nxt    = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_addr_ch_nxt = w_first_ch;
                    w_primed_nxt  = 1'b0;
                end
            end
            S_SETUP: begin
                if (r_cnt == C_DIV_END) begin
                    w_state_nxt = S_SHIFT;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = 4'd0;
                    w_sclk_nxt  = 1'b0;
                    w_din_nxt   = w_word[15];
                    w_ctrl_nxt  = {w_word[14:0], 1'b0};
                end
            end
            S_SHIFT: begin
                if (r_cnt == C_DIV_END) begin
                    w_cnt_nxt = '0;
                    if (!r_sclk) begin
                        // Rising sclk: take the ADC bit; top 4 of 16 fall off the 12-bit shifter.
                        w_sclk_nxt  = 1'b1;
                        w_shreg_nxt = {r_shreg[10:0], adc_dout};
                    end else if (r_bit == 4'd15) begin
                        w_state_nxt = S_GAP;
                        w_din_nxt   = 1'b0;
                    end else begin
                        w_sclk_nxt = 1'b0;
                        w_bit_nxt  = r_bit + 4'd1;
                        w_din_nxt  = r_ctrl[15];
                        w_ctrl_nxt = {r_ctrl[14:0], 1'b0};
                    end
                end
            end
            S_GAP: begin
                if (r_cnt == C_DIV_END) begin
                    w_cs_n_nxt = 1'b1;
                    w_capture  = r_primed;
                end
                if (r_cnt == C_GAP_END) begin
                    w_cnt_nxt = '0;
                    if (w_go) begin
                        w_state_nxt   = S_SETUP;
                        w_cs_n_nxt    = 1'b0;
                        w_prev_ch_nxt = r_addr_ch;
                        w_addr_ch_nxt = w_next_ch;
                        w_primed_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Result bank and sample port, written when cs_n rises on a primed frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample_valid <= 1'b0;
            r_sample_ch    <= 3'd0;
            r_sample_data  <= 12'd0;
            for (int i = 0; i < 8; i++) begin
                r_bank[i] <= 12'd0;
            end
        end else begin
            r_sample_valid <= w_capture;
            if (w_capture) begin
                r_bank[r_prev_ch] <= r_shreg;
                r_sample_ch       <= r_prev_ch;
                r_sample_data     <= r_shreg;
            end
        end
    end

    // Free-running display publish; reads the bank before any same-cycle capture lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp_cnt    <= '0;
            r_disp_data   <= 16'd0;
            r_disp_strobe <= 1'b0;
        end else begin
            r_disp_cnt    <= r_disp_cnt + DISP_N'(1);
            r_disp_strobe <= &r_disp_cnt;
            if (&r_disp_cnt) begin
                r_disp_data <= {1'b0, disp_ch_sel, r_bank[disp_ch_sel]};
            end
        end
    end

    assign adc_sclk     = r_sclk;
    assign adc_cs_n     = r_cs_n;
    assign adc_din      = r_din;
    assign busy         = r_busy;
    assign sample_valid = r_sample_valid;
    assign sample_ch    = r_sample_ch;
    assign sample_data  = r_sample_data;
    assign disp_data    = r_disp_data;
    assign disp_strobe  = r_disp_strobe;

endmodule
